// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The state encoding doubles as the debug view exposed on the control interface.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_RWB    = 4'd3,
    S_JR     = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_LUI   = 4'b0100;
  localparam logic [3:0] ALU_RTYPE = 4'b0111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_A      = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle. No handshake: mem_ready is a level qualifier
// sampled each cycle the controller is in a memory state (FETCH, MEMRD, MEMWR).
interface mips_multicycle_control_if #(parameter int CNT_WIDTH = 32);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 link;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [3:0]           alu_op;
  logic [1:0]           pc_src;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;
  logic [3:0]           dbg_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, link, alu_src_a, alu_src_b, alu_op, pc_src, halted,
           retired, dbg_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, link, alu_src_a, alu_src_b, alu_op, pc_src, halted,
           retired, dbg_state
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> datapath control table. Only FETCH (mem_ready)
// and BRANCH (zero) look at anything other than the state and IR opcode.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_src    = PC_SRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_src   = PC_SRC_A;
        ctrl_o.pc_write = 1'b1;
      end
      S_MEMADR, S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        if (state_i == S_IEXEC) begin
          case (opcode_i)
            OP_ANDI: ctrl_o.alu_op = ALU_AND;
            OP_ORI:  ctrl_o.alu_op = ALU_OR;
            OP_LUI:  ctrl_o.alu_op = ALU_LUI;
            default: ctrl_o.alu_op = ALU_ADD;
          endcase
        end
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_SRC_ALUOUT;
        // opcode[0] distinguishes bne from beq, so it inverts the taken sense
        ctrl_o.pc_write  = zero_i ^ opcode_i[0];
      end
      S_IWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_src    = PC_SRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.link      = opcode_i[0];
        ctrl_o.reg_write = opcode_i[0];
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o.halted = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: next-state logic, retired-instruction counter,
// and reset gating of the architectural-state strobes.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input logic                         clk,
  input logic                         reset,
  mips_multicycle_control_if.master   bus
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  ctrl_t                ctrl;

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:                         state_d = S_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          default:                          state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = (bus.funct == FUNCT_JR) ? S_JR : S_RWB;
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_RWB, S_JR, S_MEMWB, S_BRANCH, S_IWB, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge back into FETCH; a FETCH wait is not a return.
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH) retired_d = retired_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc_write   = ctrl.pc_write  & ~reset;
  assign bus.mem_read   = ctrl.mem_read  & ~reset;
  assign bus.mem_write  = ctrl.mem_write & ~reset;
  assign bus.ir_write   = ctrl.ir_write  & ~reset;
  assign bus.reg_write  = ctrl.reg_write & ~reset;
  assign bus.link       = ctrl.link      & ~reset;
  assign bus.halted     = ctrl.halted    & ~reset;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.retired    = retired_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle vector table
// plus randomised lw wait-state sequences, all checked through an expected queue.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_WIDTH(32)) bus ();

  mips_multicycle_control #(.CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected control word, field order:
  // pcw iord mrd mwr irw rdst m2r rw lnk srca | srcb | alu_op | pc_src | halted
  localparam logic [18:0] E_RST_FETCH = {10'b0000000000, 2'b01, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_FETCH     = {10'b1010100000, 2'b01, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_FETCH_W   = {10'b0010000000, 2'b01, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_DECODE    = {10'b0000000000, 2'b11, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_EXEC      = {10'b0000000001, 2'b00, 4'h7, 2'b00, 1'b0};
  localparam logic [18:0] E_RWB       = {10'b0000010100, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_JR        = {10'b1000000000, 2'b00, 4'h0, 2'b11, 1'b0};
  localparam logic [18:0] E_MEMADR    = {10'b0000000001, 2'b10, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMRD     = {10'b0110000000, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMWB     = {10'b0000001100, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMWR     = {10'b0101000000, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_RST_MEMWR = {10'b0100000000, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_BR_NT     = {10'b0000000001, 2'b00, 4'h1, 2'b01, 1'b0};
  localparam logic [18:0] E_BR_T      = {10'b1000000001, 2'b00, 4'h1, 2'b01, 1'b0};
  localparam logic [18:0] E_IEX_OR    = {10'b0000000001, 2'b10, 4'h3, 2'b00, 1'b0};
  localparam logic [18:0] E_IEX_LUI   = {10'b0000000001, 2'b10, 4'h4, 2'b00, 1'b0};
  localparam logic [18:0] E_IWB       = {10'b0000000100, 2'b00, 4'h0, 2'b00, 1'b0};
  localparam logic [18:0] E_J         = {10'b1000000000, 2'b00, 4'h0, 2'b10, 1'b0};
  localparam logic [18:0] E_JAL       = {10'b1000000110, 2'b00, 4'h0, 2'b10, 1'b0};
  localparam logic [18:0] E_HALT      = {10'b0000000000, 2'b00, 4'h0, 2'b00, 1'b1};
  localparam logic [18:0] E_RST_HALT  = 19'b0;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] c;
    logic [31:0] ret;
  } vec_t;

  vec_t        vecs[$];
  logic [54:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic add(input string nm, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [18:0] c, input logic [31:0] ret);
    vec_t v;
    v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.st = st; v.c = c; v.ret = ret;
    vecs.push_back(v);
  endtask

  // driver + scoreboard: drive on negedge, compare 3 ns later, well before posedge
  task automatic run_vec(input vec_t v);
    logic [54:0] got;
    logic [54:0] exp;
    @(negedge clk);
    reset         = v.rst;
    bus.opcode    = v.op;
    bus.funct     = v.fn;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    exp_q.push_back({v.st, v.c, v.ret});
    #3;
    got = {bus.dbg_state,
           bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
           bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.link, bus.alu_src_a,
           bus.alu_src_b, bus.alu_op, bus.pc_src, bus.halted, bus.retired};
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ctrl=%05h ret=%0d, expected st=%0d ctrl=%05h ret=%0d",
               v.name, got[54:51], got[50:32], got[31:0], exp[54:51], exp[50:32], exp[31:0]);
    end
  endtask

  task automatic hand(input string nm, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [18:0] c, input logic [31:0] ret);
    vec_t v;
    v.name = nm; v.rst = 1'b0; v.op = op; v.fn = F_ADD; v.z = 1'($urandom_range(0, 1));
    v.rdy = rdy; v.st = st; v.c = c; v.ret = ret;
    run_vec(v);
  endtask

  initial begin
    int r;
    int k;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    add("reset",      1, OP_RTYPE, F_ADD, 0, 1, S_FETCH,  E_RST_FETCH, 0);
    add("r_fetch",    0, OP_RTYPE, F_ADD, 0, 1, S_FETCH,  E_FETCH,  0);
    add("r_decode",   0, OP_RTYPE, F_ADD, 0, 1, S_DECODE, E_DECODE, 0);
    add("r_exec",     0, OP_RTYPE, F_ADD, 0, 1, S_EXEC,   E_EXEC,   0);
    add("r_rwb",      0, OP_RTYPE, F_ADD, 0, 1, S_RWB,    E_RWB,    0);
    add("lw_fetch",   0, OP_LW,    F_ADD, 0, 1, S_FETCH,  E_FETCH,  1);
    add("lw_decode",  0, OP_LW,    F_ADD, 0, 1, S_DECODE, E_DECODE, 1);
    add("lw_memadr",  0, OP_LW,    F_ADD, 0, 1, S_MEMADR, E_MEMADR, 1);
    for (int i = 0; i < 3; i++)
      add("lw_wait",  0, OP_LW,    F_ADD, 0, 0, S_MEMRD,  E_MEMRD,  1);
    add("lw_rd",      0, OP_LW,    F_ADD, 0, 1, S_MEMRD,  E_MEMRD,  1);
    add("lw_wb",      0, OP_LW,    F_ADD, 0, 1, S_MEMWB,  E_MEMWB,  1);
    add("beq0_fetch", 0, OP_BEQ,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  2);
    add("beq0_dec",   0, OP_BEQ,   F_ADD, 0, 1, S_DECODE, E_DECODE, 2);
    add("beq0_br",    0, OP_BEQ,   F_ADD, 0, 1, S_BRANCH, E_BR_NT,  2);
    add("bne0_fetch", 0, OP_BNE,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  3);
    add("bne0_dec",   0, OP_BNE,   F_ADD, 0, 1, S_DECODE, E_DECODE, 3);
    add("bne0_br",    0, OP_BNE,   F_ADD, 0, 1, S_BRANCH, E_BR_T,   3);
    add("beq1_fetch", 0, OP_BEQ,   F_ADD, 1, 1, S_FETCH,  E_FETCH,  4);
    add("beq1_dec",   0, OP_BEQ,   F_ADD, 1, 1, S_DECODE, E_DECODE, 4);
    add("beq1_br",    0, OP_BEQ,   F_ADD, 1, 1, S_BRANCH, E_BR_T,   4);
    add("bne1_fetch", 0, OP_BNE,   F_ADD, 1, 1, S_FETCH,  E_FETCH,  5);
    add("bne1_dec",   0, OP_BNE,   F_ADD, 1, 1, S_DECODE, E_DECODE, 5);
    add("bne1_br",    0, OP_BNE,   F_ADD, 1, 1, S_BRANCH, E_BR_NT,  5);
    add("jal_fetch",  0, OP_JAL,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  6);
    add("jal_dec",    0, OP_JAL,   F_ADD, 0, 1, S_DECODE, E_DECODE, 6);
    add("jal_jump",   0, OP_JAL,   F_ADD, 0, 1, S_JUMP,   E_JAL,    6);
    add("j_fetch",    0, OP_J,     F_ADD, 0, 1, S_FETCH,  E_FETCH,  7);
    add("j_dec",      0, OP_J,     F_ADD, 0, 1, S_DECODE, E_DECODE, 7);
    add("j_jump",     0, OP_J,     F_ADD, 0, 1, S_JUMP,   E_J,      7);
    add("ori_fetch",  0, OP_ORI,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  8);
    add("ori_dec",    0, OP_ORI,   F_ADD, 0, 1, S_DECODE, E_DECODE, 8);
    add("ori_iexec",  0, OP_ORI,   F_ADD, 0, 1, S_IEXEC,  E_IEX_OR, 8);
    add("ori_iwb",    0, OP_ORI,   F_ADD, 0, 1, S_IWB,    E_IWB,    8);
    add("lui_fetch",  0, OP_LUI,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  9);
    add("lui_dec",    0, OP_LUI,   F_ADD, 0, 1, S_DECODE, E_DECODE, 9);
    add("lui_iexec",  0, OP_LUI,   F_ADD, 0, 1, S_IEXEC,  E_IEX_LUI, 9);
    add("lui_iwb",    0, OP_LUI,   F_ADD, 0, 1, S_IWB,    E_IWB,    9);
    add("jr_fetch",   0, OP_RTYPE, F_JR,  0, 1, S_FETCH,  E_FETCH,  10);
    add("jr_dec",     0, OP_RTYPE, F_JR,  0, 1, S_DECODE, E_DECODE, 10);
    add("jr_exec",    0, OP_RTYPE, F_JR,  0, 1, S_EXEC,   E_EXEC,   10);
    add("jr_jr",      0, OP_RTYPE, F_JR,  0, 1, S_JR,     E_JR,     10);
    add("sw_fwait",   0, OP_SW,    F_ADD, 0, 0, S_FETCH,  E_FETCH_W, 11);
    add("sw_fetch",   0, OP_SW,    F_ADD, 0, 1, S_FETCH,  E_FETCH,  11);
    add("sw_dec",     0, OP_SW,    F_ADD, 0, 1, S_DECODE, E_DECODE, 11);
    add("sw_memadr",  0, OP_SW,    F_ADD, 0, 1, S_MEMADR, E_MEMADR, 11);
    add("sw_wait",    0, OP_SW,    F_ADD, 0, 0, S_MEMWR,  E_MEMWR,  11);
    add("sw_wr",      0, OP_SW,    F_ADD, 0, 1, S_MEMWR,  E_MEMWR,  11);
    add("halt_fetch", 0, OP_BAD,   F_ADD, 0, 1, S_FETCH,  E_FETCH,  12);
    add("halt_dec",   0, OP_BAD,   F_ADD, 0, 1, S_DECODE, E_DECODE, 12);
    for (int i = 0; i < 10; i++)
      add("halt_hold", 0, OP_BAD,  F_ADD, 0, 1, S_HALT,   E_HALT,   12);
    add("halt_rst",   1, OP_BAD,   F_ADD, 0, 1, S_HALT,   E_RST_HALT, 12);
    add("post_rst",   0, OP_SW,    F_ADD, 0, 1, S_FETCH,  E_FETCH,  0);
    add("swr_dec",    0, OP_SW,    F_ADD, 0, 1, S_DECODE, E_DECODE, 0);
    add("swr_memadr", 0, OP_SW,    F_ADD, 0, 1, S_MEMADR, E_MEMADR, 0);
    add("swr_rst",    1, OP_SW,    F_ADD, 0, 0, S_MEMWR,  E_RST_MEMWR, 0);

    // hold reset through a couple of edges so the state is defined
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // lw with random memory wait counts; the first row also shows reset-in-MEMWR landed in FETCH
    r = 0;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(0, 4);
      hand("rlw_fetch",  OP_LW, 1'b1, S_FETCH,  E_FETCH,  r);
      hand("rlw_decode", OP_LW, 1'b1, S_DECODE, E_DECODE, r);
      hand("rlw_memadr", OP_LW, 1'b1, S_MEMADR, E_MEMADR, r);
      for (int w = 0; w < k; w++)
        hand("rlw_wait", OP_LW, 1'b0, S_MEMRD,  E_MEMRD,  r);
      hand("rlw_rd",     OP_LW, 1'b1, S_MEMRD,  E_MEMRD,  r);
      hand("rlw_wb",     OP_LW, 1'b1, S_MEMWB,  E_MEMWB,  r);
      r++;
    end
    hand("rlw_final", OP_RTYPE, 1'b0, S_FETCH, E_FETCH_W, r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore FSM that sequences a multicycle MIPS datapath: single shared instruction/data memory, IR, A/B/ALUOut registers, one ALU.
- Replaces the single-cycle combinational control path.
- Per state it drives all datapath strobes and mux selects.
- Supports wait states on the shared memory, counts retired instructions, and halts on an illegal opcode.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  shared memory has completed the current access
- pc_write  out  1  PC load enable, branch decision already resolved
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- link  out  1  force write register 31 and write data PC+4 (JAL)
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  4  ALU operation class, to ALU control
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut (branch), 10 = jump target, 11 = A (JR)
- halted  out  1  FSM in HALT
- retired  out  CNT_WIDTH  count of completed instructions

Behaviour:
- Reset:
  - reset high at a clock edge → state = FETCH, retired = 0.
  - While reset is high, pc_write, mem_read, mem_write, ir_write, reg_write and link are forced to 0; halted = 0.
  - Reset takes precedence in every state, including a pending memory wait.
- Outputs are decoded from the state only, except pc_write in BRANCH and the mem_ready gating in FETCH.
- Unlisted outputs are 0; alu_op defaults to ADD.
- States and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. ir_write and pc_write are asserted only when mem_ready=1. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state by opcode:
    - 000000 → EXEC
    - 100011 (lw) and 101011 (sw) → MEMADR
    - 000100 (beq) and 000101 (bne) → BRANCH
    - 001000 (addi), 001100 (andi), 001101 (ori), 001111 (lui) → IEXEC
    - 000010 (j) and 000011 (jal) → JUMP
    - any other opcode → HALT
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=RTYPE. Goes to JR if funct=001000, otherwise RWB.
  - RWB: reg_dst=1, reg_write=1 → FETCH.
  - JR: pc_src=11, pc_write=1 → FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD → MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then → MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
  - MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01. pc_write = zero XOR opcode[0] (beq taken on zero, bne taken on !zero) → FETCH.
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_op by opcode (ADD, AND, OR, LUI) → IWB.
  - IWB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
  - JUMP: pc_src=10, pc_write=1. If opcode[0]=1, also link=1 and reg_write=1 → FETCH.
  - HALT: halted=1, all strobes 0. Absorbing state; only reset exits.
- Latencies with mem_ready stuck at 1:
  - R-type 4 cycles; lw 5; sw 4; beq/bne 3; I-type ALU 4; j/jal 3; jr 4.
  - Each memory wait cycle adds 1.
- retired:
  - Increments by 1 on the cycle the FSM returns to FETCH from any non-reset state.
  - Wraps modulo 2^CNT_WIDTH.
  - Does not count HALT.
- Opcode and funct are sampled only in DECODE/EXEC. IR is stable after FETCH, so no input registering is needed.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum (4-bit encoding)
  - opcode constants
  - funct JR constant
  - alu_op constants: ADD=0000, SUB=0001, AND=0010, OR=0011, LUI=0100, RTYPE=0111
  - pc_src and alu_src_b encodings
- One sub-module, mips_ctrl_decode: pure combinational state → outputs table.
- The FSM next-state logic and the counter stay in the top module.

Test Plan:
- Reset, then opcode 000000 / funct 100000 with mem_ready=1 → FETCH, DECODE, EXEC, RWB, FETCH. reg_write=1 only in RWB with reg_dst=1. retired=1 after 4 cycles.
- lw (100011) with mem_ready low for 3 cycles in MEMRD → mem_read and i_or_d=1 held 4 cycles. reg_write with mem_to_reg=1 at cycle 8. retired=1.
- beq with zero=0, then bne with zero=0 → pc_write=0 in the first BRANCH, pc_write=1 with pc_src=01 in the second. Each instruction takes 3 cycles.
- jal (000011) → JUMP with pc_src=10, pc_write=1, link=1, reg_write=1. j (000010) → link=0, reg_write=0.
- opcode 111111 → HALT after DECODE. halted=1, all strobes 0 for 10 cycles, retired frozen. Asserting reset → FETCH, halted=0, retired=0.
- Reset asserted in MEMWR with mem_ready=0 → mem_write=0 that cycle, FETCH next cycle. No register write occurs.
